// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_entry_t : one queued fetch result (instruction word + its word PC)
//   XLEN          : datapath / PC width
package fetch_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, used as the fetch queue.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   flush_i           : drop all entries (wins over push/pop)
//   push_i/push_data_i: write one entry at the tail
//   pop_i             : retire the head entry (caller guarantees non-empty)
//   count_o           : occupancy, 0..DEPTH
//   head_o            : entry at the head, meaningless when count_o == 0
// The caller guarantees no push when full without a simultaneous pop.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output T              head_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // pointers are log2(DEPTH) wide so they wrap modulo DEPTH for free
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: occupancy decides what is visible
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_i) mem_q[wptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the word PC, reads a 1-cycle-latency
// instruction memory, queues PC-tagged instructions for the decoder and
// honours redirects from execute (which flush everything queued/in flight).
//   CLK, RSTN            : clock, synchronous active-low reset
//   IMEM_REQ/IMEM_ADDR   : memory read request and word address (= fetch PC)
//   IMEM_RDATA           : data for the request issued the previous cycle
//   REDIRECT/REDIRECT_PC : one-cycle redirect pulse and new fetch target
//   OUT_VALID/OUT_READY  : decoder handshake, OUT_INSTR/OUT_PC = queue head
//   DONE                 : everything up to LAST_PC delivered, nothing pending
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'd0,
  parameter logic [XLEN-1:0] LAST_PC  = 32'd35
) (
  input  logic            CLK,
  input  logic            RSTN,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_INSTR,
  output logic [XLEN-1:0] OUT_PC,
  output logic            DONE
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;   // PC of the request now in flight
  logic            inflight_q, inflight_d;
  logic            done_q, done_d;
  logic            run_q;                // low for the first cycle out of reset

  logic [CW-1:0]   count;
  fetch_entry_t    head, push_entry;
  logic            pc_ok, below_cap, issue, push, pop;

  assign pc_ok     = (fetch_pc_q <= LAST_PC);
  // reserving a slot for the in-flight word means a response always fits
  assign below_cap = ((32'(count) + 32'(inflight_q)) < 32'(DEPTH));
  assign issue     = run_q & ~REDIRECT & pc_ok & below_cap;
  assign push      = inflight_q & ~REDIRECT;
  assign pop       = OUT_VALID & OUT_READY & ~REDIRECT;

  assign push_entry = '{instr: IMEM_RDATA, pc: tag_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    if (REDIRECT) begin
      fetch_pc_d = REDIRECT_PC;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
        tag_pc_d   = fetch_pc_q;
      end
      done_d = ~pc_ok & (count == '0) & ~inflight_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      run_q      <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk_i       (CLK),
    .rst_ni      (RSTN),
    .flush_i     (REDIRECT),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign IMEM_REQ  = issue;
  assign IMEM_ADDR = fetch_pc_q;
  assign OUT_VALID = (count != '0);
  assign OUT_INSTR = head.instr;
  assign OUT_PC    = head.pc;
  assign DONE      = done_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = 32'd0;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;
  logic        DONE;

  int n_tests = 0;
  int n_fail  = 0;
  logic bad_req = 1'b0;

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'd0), .LAST_PC(32'd35)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // memory image: mem[i] = i + 100, one-cycle read latency
  always @(posedge CLK) begin
    if (IMEM_REQ) IMEM_RDATA <= IMEM_ADDR + 32'd100;
    if (RSTN && IMEM_REQ && IMEM_ADDR > 32'd35) bad_req <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // one reset edge, release, then check the idle state (cycle 0)
  task automatic do_reset();
    RSTN = 1'b0;
    REDIRECT = 1'b0;
    tick();
    RSTN = 1'b1;
    #1;
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_req",   32'(IMEM_REQ),  32'd0);
    chk("rst_done",  32'(DONE),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; OUT_READY = 1'b0;

    // streaming from reset, then redirect to 20 while 5,6,7 queued and 8 in flight
    do_reset();
    OUT_READY = 1'b1;
    tick(); #1;
    chk("t1_c1_req",  32'(IMEM_REQ), 32'd1);
    chk("t1_c1_addr", IMEM_ADDR, 32'd0);
    chk("t1_c1_vld",  32'(OUT_VALID), 32'd0);
    tick(); #1;
    chk("t1_c2_vld",  32'(OUT_VALID), 32'd0);
    chk("t1_c2_addr", IMEM_ADDR, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("t1_vld",   32'(OUT_VALID), 32'd1);
      chk("t1_pc",    OUT_PC, 32'(k));
      chk("t1_instr", OUT_INSTR, 32'(k + 100));
    end
    tick(); OUT_READY = 1'b0;                // c8
    tick();                                  // c9
    tick();                                  // c10
    OUT_READY = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'd20;
    #1;
    chk("t3_head_pc", OUT_PC, 32'd5);
    chk("t3_req_redir", 32'(IMEM_REQ), 32'd0);
    tick(); REDIRECT = 1'b0; #1;             // c11
    chk("t3_c1_vld",  32'(OUT_VALID), 32'd0);
    chk("t3_c1_req",  32'(IMEM_REQ), 32'd1);
    chk("t3_c1_addr", IMEM_ADDR, 32'd20);
    tick(); #1;                              // c12
    chk("t3_c2_vld",  32'(OUT_VALID), 32'd0);
    chk("t3_c2_addr", IMEM_ADDR, 32'd21);
    tick(); #1;                              // c13
    chk("t3_c3_vld",  32'(OUT_VALID), 32'd1);
    chk("t3_c3_pc",   OUT_PC, 32'd20);
    chk("t3_c3_instr", OUT_INSTR, 32'd120);
    tick(); #1;
    chk("t3_c4_pc",   OUT_PC, 32'd21);

    // backpressure: queue fills to DEPTH, then drains in order
    do_reset();
    OUT_READY = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    chk("t2_c4_req",  32'(IMEM_REQ), 32'd1);
    chk("t2_c4_addr", IMEM_ADDR, 32'd3);
    tick(); #1;
    chk("t2_c5_req",  32'(IMEM_REQ), 32'd0);
    for (int c = 6; c <= 10; c++) tick();
    OUT_READY = 1'b1; #1;
    chk("t2_c10_req", 32'(IMEM_REQ), 32'd0);
    chk("t2_c10_pc",  OUT_PC, 32'd0);
    tick(); #1;
    chk("t2_c11_pc",   OUT_PC, 32'd1);
    chk("t2_c11_req",  32'(IMEM_REQ), 32'd1);
    chk("t2_c11_addr", IMEM_ADDR, 32'd4);
    for (int k = 2; k <= 4; k++) begin
      tick(); #1;
      chk("t2_drain_vld", 32'(OUT_VALID), 32'd1);
      chk("t2_drain_pc",  OUT_PC, 32'(k));
    end
    chk("t2_instr4", OUT_INSTR, 32'd104);

    // back-to-back redirects 12 then 30, then run to LAST_PC and halt
    do_reset();
    OUT_READY = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'd12;   // c4
    tick();                                  // c5
    REDIRECT_PC = 32'd30; #1;
    chk("t4_c5_req", 32'(IMEM_REQ), 32'd0);
    chk("t4_c5_vld", 32'(OUT_VALID), 32'd0);
    tick(); REDIRECT = 1'b0; #1;             // c6
    chk("t4_c6_addr", IMEM_ADDR, 32'd30);
    chk("t4_c6_vld",  32'(OUT_VALID), 32'd0);
    tick(); #1;                              // c7
    chk("t4_c7_vld",  32'(OUT_VALID), 32'd0);
    for (int k = 30; k <= 35; k++) begin      // c8..c13
      tick(); #1;
      chk("t5_vld",   32'(OUT_VALID), 32'd1);
      chk("t5_pc",    OUT_PC, 32'(k));
      chk("t5_instr", OUT_INSTR, 32'(k + 100));
      if (k == 33) chk("t5_last_addr", IMEM_ADDR, 32'd35);
      if (k >= 34) chk("t5_halt_req", 32'(IMEM_REQ), 32'd0);
    end
    tick(); #1;                              // c14
    chk("t5_empty", 32'(OUT_VALID), 32'd0);
    tick(); #1;                              // c15
    chk("t5_done", 32'(DONE), 32'd1);
    REDIRECT = 1'b1; REDIRECT_PC = 32'd4;
    tick(); REDIRECT = 1'b0; #1;             // c16
    chk("t5_done_clr", 32'(DONE), 32'd0);
    chk("t5_resume_req",  32'(IMEM_REQ), 32'd1);
    chk("t5_resume_addr", IMEM_ADDR, 32'd4);
    tick(); tick(); #1;                      // c18
    chk("t5_resume_pc",    OUT_PC, 32'd4);
    chk("t5_resume_instr", OUT_INSTR, 32'd104);
    chk("t5_no_addr36", 32'(bad_req), 32'd0);

    // reset with 3 queued entries and one fetch in flight
    do_reset();
    OUT_READY = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    #1;
    chk("t6_pre_vld", 32'(OUT_VALID), 32'd1);
    chk("t6_pre_pc",  OUT_PC, 32'd0);
    do_reset();
    OUT_READY = 1'b1;
    tick(); #1;
    chk("t6_c1_addr", IMEM_ADDR, 32'd0);
    chk("t6_c1_vld",  32'(OUT_VALID), 32'd0);
    tick(); #1;
    chk("t6_c2_vld",  32'(OUT_VALID), 32'd0);
    tick(); #1;
    chk("t6_c3_pc",    OUT_PC, 32'd0);
    chk("t6_c3_instr", OUT_INSTR, 32'd100);
    tick(); #1;
    chk("t6_c4_pc",    OUT_PC, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
